// File: rtl/core_pkg.sv
// Shared core definitions: fetch geometry, PC step, reset PC and the IF/ID record.
package core_pkg;

  localparam int unsigned XLEN_DEF    = 64;
  localparam int unsigned IMEM_AW_DEF = 6;
  localparam int unsigned IW_DEF      = 32;
  localparam int unsigned PC_INC      = 4;

  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;

  // IF/ID contents as seen by the decode stage.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [IW_DEF-1:0]   instr;
    logic                valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-ROM bus: word address out, combinational read data back.
interface fetch_stage_if #(
  parameter int unsigned IMEM_AW = core_pkg::IMEM_AW_DEF,
  parameter int unsigned IW      = core_pkg::IW_DEF
);

  logic [IMEM_AW-1:0] imem_addr;
  logic [IW-1:0]      imem_q;

  modport master (output imem_addr, input imem_q);
  modport slave  (input imem_addr, output imem_q);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset and flush clear it, stall holds it.
module if_id_reg #(
  parameter int unsigned N  = core_pkg::XLEN_DEF,
  parameter int unsigned IW = core_pkg::IW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          stall_i,
  input  logic [N-1:0]  pc_i,
  input  logic [IW-1:0] instr_i,
  output logic [N-1:0]  pc_o,
  output logic [IW-1:0] instr_o,
  output logic          valid_o
);

  import core_pkg::*;

  logic [N-1:0]  pc_q;
  logic [IW-1:0] instr_q;
  logic          valid_q;

  // Flush outranks stall so a squashed slot never survives a hazard hold.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
      valid_q <= 1'b1;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 fetch front end: PC register, next-PC select, ROM addressing, IF/ID capture.
module fetch_stage #(
  parameter int unsigned    N        = core_pkg::XLEN_DEF,
  parameter int unsigned    IMEM_AW  = core_pkg::IMEM_AW_DEF,
  parameter int unsigned    IW       = core_pkg::IW_DEF,
  parameter logic [N-1:0]   RESET_PC = N'(core_pkg::RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCSrc_F,
  input  logic [N-1:0]      PCBranch_F,
  input  logic              stall_F,
  input  logic              flush_D,
  fetch_stage_if.master     imem,
  output logic [N-1:0]      pc_F,
  output logic [N-1:0]      pc_D,
  output logic [IW-1:0]     instr_D,
  output logic              valid_D
);

  import core_pkg::*;

  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] pc_seq, pc_tgt;

  assign pc_seq = pc_q + N'(PC_INC);
  // Branch targets are word aligned; drop the low two bits.
  assign pc_tgt = PCBranch_F & ~N'(3);

  // Next-PC select: taken branch beats stall, otherwise step by one word.
  always_comb begin
    pc_d = pc_seq;
    if (PCSrc_F) begin
      pc_d = pc_tgt;
    end else if (stall_F) begin
      pc_d = pc_q;
    end
  end

  // PC register; ROM address is derived only from this, never from the branch inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_F           = pc_q;
  assign imem.imem_addr = pc_q[IMEM_AW+1:2];

  if_id_reg #(
    .N  (N),
    .IW (IW)
  ) u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush_D),
    .stall_i (stall_F),
    .pc_i    (pc_q),
    .instr_i (imem.imem_q),
    .pc_o    (pc_D),
    .instr_o (instr_D),
    .valid_o (valid_D)
  );

endmodule
